// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, commit kinds and controller states.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } md_op_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // What happens to HI/LO when the busy counter expires.
  typedef enum logic [1:0] {
    CM_NONE  = 2'd0,
    CM_WRITE = 2'd1,
    CM_ADD   = 2'd2,
    CM_SUB   = 2'd3
  } commit_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_mul_op(md_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_acc_op(md_op_e op);
    return (op == MDU_MADD) || (op == MDU_MADDU) ||
           (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage to multiply/divide unit connection. The pipeline side is the
// master; the MDU is the slave.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, md_op, a, b, d_is_md,
    input  busy, stall_md, hi, lo, rd_data
  );

  modport slave (
    input  start, md_op, a, b, d_is_md,
    output busy, stall_md, hi, lo, rd_data
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational arithmetic for the MDU: 64-bit product, or {remainder, quotient}
// for divides. A single unsigned divider serves both DIV and DIVU.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  md_op_e      md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        div_signed;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_res, r_res;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign div_signed = (md_op_i == MDU_DIV);
  assign a_mag      = (div_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
  assign b_mag      = (div_signed && b_i[31]) ? (32'd0 - b_i) : b_i;
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign q_res      = (div_signed && (a_i[31] ^ b_i[31])) ? (32'd0 - q_mag) : q_mag;
  assign r_res      = (div_signed && a_i[31]) ? (32'd0 - r_mag) : r_mag;
  assign div_zero_o = (b_i == 32'd0);

  always_comb begin
    res_o = 64'd0;
    case (md_op_i)
      MDU_MULT, MDU_MADD, MDU_MSUB:    res_o = prod_s;
      MDU_MULTU, MDU_MADDU, MDU_MSUBU: res_o = prod_u;
      MDU_DIV, MDU_DIVU:               res_o = {r_res, q_res};
      default:                         res_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: busy down-counter, pending result, HI/LO
// and D-stage stall. Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave md
);

  // state   | meaning
  // ST_IDLE | counter zero, HI/LO stable, accepts start / MTHI / MTLO
  // ST_BUSY | counter running; pending result commits on the 1->0 step

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  commit_e          cm_q, cm_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [63:0] arith_res;
  logic        div_zero;
  logic        op_mul, op_div, op_acc, op_sub;
  logic        start_ok, mt_ok, commit;

  mdu_arith u_arith (
    .md_op_i    (md.md_op),
    .a_i        (md.a),
    .b_i        (md.b),
    .res_o      (arith_res),
    .div_zero_o (div_zero)
  );

  always_comb begin
    op_mul = is_mul_op(md.md_op);
    op_div = is_div_op(md.md_op);
`ifdef MDU_MADD_EN
    op_acc = is_acc_op(md.md_op);
`else
    op_acc = 1'b0;
`endif
    op_sub = (md.md_op == MDU_MSUB) || (md.md_op == MDU_MSUBU);
  end

  // A start always wins over MTHI/MTLO, even when its own op is not accepted.
  assign start_ok = md.start && (op_mul || op_div || op_acc) && (state_q == ST_IDLE);
  assign mt_ok    = !md.start && (state_q == ST_IDLE) &&
                    ((md.md_op == MDU_MTHI) || (md.md_op == MDU_MTLO));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    md.busy  = (state_q == ST_BUSY);
    commit   = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
  end

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    cm_d   = cm_q;
    hi_d   = hi_q;
    lo_d   = lo_q;

    if (start_ok) begin
      cnt_d  = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      pend_d = arith_res;
      if (op_div && div_zero) cm_d = CM_NONE;
      else if (op_acc)        cm_d = op_sub ? CM_SUB : CM_ADD;
      else                    cm_d = CM_WRITE;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (commit) begin
      case (cm_q)
        CM_WRITE: {hi_d, lo_d} = pend_q;
`ifdef MDU_MADD_EN
        // Accumulator is HI/LO as they stand at the commit edge.
        CM_ADD:   {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
        CM_SUB:   {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
`endif
        default:  {hi_d, lo_d} = {hi_q, lo_q};
      endcase
    end else if (mt_ok) begin
      if (md.md_op == MDU_MTHI) hi_d = md.a;
      else                      lo_d = md.a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 64'd0;
      cm_q   <= CM_NONE;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      cm_q   <= cm_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.stall_md = md.d_is_md && (md.start || md.busy);
  assign md.rd_data  = (md.md_op == MDU_MFHI) ? hi_q :
                       (md.md_op == MDU_MFLO) ? lo_q : 32'd0;

endmodule
